cache_line_writer: RTL and testbench

- Downstream stage of the cache controller's refill path.
- On a cache write request, it captures the 4096-bit page fetched from DDR and the target cache page index.
- It writes the page into the word-organised cache data RAM as 128 sequential 32-bit writes, then signals completion on cache_write_buffer_end.
- It sits between the cache controller and the cache data RAM.

---
 rtl/cache_line_writer.sv | 111 +++++++++++
 tb/tb_cache_line_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_line_writer.sv
// rtl/cache_line_writer.sv - writes a captured cache line into the word-organised cache data RAM
module cache_line_writer #(
    parameter int LINE_BITS = 4096,
    parameter int WORD_BITS = 32,
    parameter int PAGE_BITS = 2,
    parameter int IDX_BITS  = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cache_we,
    input  logic [PAGE_BITS-1:0]          cache_page,
    input  logic [LINE_BITS-1:0]          cache_data_write,
    output logic                          cache_write_buffer_end,
    output logic                          busy,
    output logic                          ram_we,
    output logic [PAGE_BITS+IDX_BITS-1:0] ram_addr,
    output logic [WORD_BITS-1:0]          ram_wdata
);

    localparam int WORDS = LINE_BITS / WORD_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [IDX_BITS-1:0]             idx;
    logic [IDX_BITS-1:0]             idx_next;
    logic [IDX_BITS-1:0]             idx_inc;
    logic [PAGE_BITS-1:0]            page_q;
    logic [LINE_BITS-1:0]            line_q;
    logic                            capture;
    logic [PAGE_BITS+IDX_BITS-1:0]   addr_next;
    logic [WORD_BITS-1:0]            wdata_next;

    assign idx_inc = idx + 1'b1;

    // ram_addr/ram_wdata are registered one word ahead so they hold their
    // last written values once the burst ends.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        capture    = 1'b0;
        addr_next  = ram_addr;
        wdata_next = ram_wdata;
        unique case (state)
            IDLE: begin
                if (cache_we) begin
                    state_next = WRITE;
                    idx_next   = '0;
                    capture    = 1'b1;
                    addr_next  = {cache_page, {IDX_BITS{1'b0}}};
                    wdata_next = cache_data_write[WORD_BITS-1:0];
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next   = idx_inc;
                    addr_next  = {page_q, idx_inc};
                    wdata_next = line_q[int'(idx_inc) * WORD_BITS +: WORD_BITS];
                end
            end
            DONE: begin
                if (!cache_we) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx       <= '0;
            page_q    <= '0;
            line_q    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            idx       <= idx_next;
            ram_addr  <= addr_next;
            ram_wdata <= wdata_next;
            if (capture) begin
                page_q <= cache_page;
                line_q <= cache_data_write;
            end
        end
    end

    assign ram_we                 = (state == WRITE);
    assign busy                   = (state == WRITE);
    assign cache_write_buffer_end = (state == DONE);

endmodule

// File: tb/tb_cache_line_writer.sv
// tb/tb_cache_line_writer.sv - randomized scoreboard bench for cache_line_writer
module tb_cache_line_writer;

    logic          clk;
    logic          reset;
    logic          cache_we;
    logic [1:0]    cache_page;
    logic [4095:0] cache_data_write;
    logic          cache_write_buffer_end;
    logic          busy;
    logic          ram_we;
    logic [8:0]    ram_addr;
    logic [31:0]   ram_wdata;

    cache_line_writer dut (
        .clk                    (clk),
        .reset                  (reset),
        .cache_we               (cache_we),
        .cache_page             (cache_page),
        .cache_data_write       (cache_data_write),
        .cache_write_buffer_end (cache_write_buffer_end),
        .busy                   (busy),
        .ram_we                 (ram_we),
        .ram_addr               (ram_addr),
        .ram_wdata              (ram_wdata)
    );

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t got;
    int  total = 0;
    int  bad = 0;
    int  wr_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the next expected word.
    always @(negedge clk) begin
        if (reset) begin
            check("busy_tracks_we", 64'(busy), 64'(ram_we));
            if (ram_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(ram_addr), 64'h1ff_dead);
                end else begin
                    got = exp_q.pop_front();
                    check("wr_addr", 64'(ram_addr), 64'(got.addr));
                    check("wr_data", 64'(ram_wdata), 64'(got.data));
                end
                wr_count++;
            end
        end
    end

    function automatic logic [4095:0] rand_line();
        logic [4095:0] r;
        for (int k = 0; k < 128; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [4095:0] a5_line();
        logic [4095:0] r;
        for (int k = 0; k < 128; k++) r[k*32 +: 32] = 32'hA500_0000 + 32'(k);
        return r;
    endfunction

    task automatic push_expected(input logic [1:0] pg, input logic [4095:0] ln, input int words);
        wr_t e;
        for (int k = 0; k < words; k++) begin
            e.addr = 9'(int'(pg) * 128 + k);
            e.data = ln[k*32 +: 32];
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; capture happens on the next rising edge.
    task automatic refill(input logic [1:0] pg, input logic [4095:0] ln,
                          input bit change_mid, input bit drop_early, input int hold);
        int n;
        int we_cnt;
        cache_page       = pg;
        cache_data_write = ln;
        cache_we         = 1'b1;
        push_expected(pg, ln, 128);
        n = 0;
        we_cnt = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (ram_we) we_cnt++;
            if (n == 10 && change_mid) begin
                cache_page       = 2'd1;
                cache_data_write = ~ln;
            end
            if (n == 20 && drop_early) cache_we = 1'b0;
            if (cache_write_buffer_end) break;
        end
        check("end_latency", 64'(n), 64'd130);
        check("we_cycles", 64'(we_cnt), 64'd128);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        if (!drop_early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("end_held", 64'(cache_write_buffer_end), 64'd1);
                check("we_low_in_done", 64'(ram_we), 64'd0);
            end
            cache_we = 1'b0;
        end
        @(posedge clk);
        #1;
        check("end_fall", 64'({cache_write_buffer_end, busy, ram_we}), 64'd0);
    endtask

    task automatic reset_mid_burst();
        logic [4095:0] ln;
        int base;
        int n;
        ln = rand_line();
        cache_page       = 2'd2;
        cache_data_write = ln;
        cache_we         = 1'b1;
        push_expected(2'd2, ln, 50);
        base = wr_count;
        n = 0;
        while ((wr_count - base) < 50 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_wait", 64'(wr_count - base), 64'd50);
        reset = 1'b0;
        #1;
        check("rst_async_out", 64'({ram_we, busy, cache_write_buffer_end}), 64'd0);
        check("rst_queue", 64'(exp_q.size()), 64'd0);
        cache_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_end_after_rst", 64'({ram_we, cache_write_buffer_end}), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        cache_we         = 1'b0;
        cache_page       = '0;
        cache_data_write = '0;
        repeat (3) @(negedge clk);
        check("in_reset", 64'({ram_we, busy, cache_write_buffer_end, ram_addr, ram_wdata}), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_reset_idle",
                  64'({ram_we, busy, cache_write_buffer_end, ram_addr, ram_wdata}), 64'd0);
        end
        @(posedge clk);
        #1;

        refill(2'd2, a5_line(), 1'b0, 1'b0, 0);
        refill(2'd2, a5_line(), 1'b1, 1'b0, 0);
        refill(2'd3, rand_line(), 1'b0, 1'b0, 5);
        refill(2'd1, rand_line(), 1'b0, 1'b1, 0);
        reset_mid_burst();
        refill(2'd0, rand_line(), 1'b0, 1'b0, 1);
        for (int t = 0; t < 4; t++) begin
            refill(2'($urandom_range(0, 3)), rand_line(), 1'($urandom_range(0, 1)),
                   1'b0, int'($urandom_range(0, 3)));
        end
        repeat (5) @(negedge clk);
        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
